// File: rtl/dcache_fill_unit.sv
// dcache_fill_unit: services a dCache miss from the LU-MEM bank.
// It stalls the bank, issues one line-aligned request to main memory, collects
// LINE_WORDS in-order beats, then presents the full line to the dCache fill
// port. In the same cycle it returns the critical word and its ROB tag to MEM.
//
//   state | meaning
//   IDLE  | no miss outstanding; a miss is accepted when miss_valid=1 and flush=0
//   REQ   | one-cycle request pulse to main memory
//   FILL  | collecting beats into the line buffer
//   DRAIN | miss squashed; absorbing the remaining beats without keeping them
//   RESP  | one-cycle fill_valid pulse; MEM is released
module dcache_fill_unit #(
    parameter int PADDR_WIDTH = 20,
    parameter int DATA_SIZE   = 32,
    parameter int ROB_WIDTH   = 4,
    parameter int LINE_WORDS  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            miss_valid,
    input  logic [PADDR_WIDTH-1:0]          miss_paddr,
    input  logic [ROB_WIDTH-1:0]            miss_tag,
    input  logic                            flush,
    output logic                            stall_MEM,
    output logic                            mem_req,
    output logic [PADDR_WIDTH-1:0]          mem_addr,
    input  logic                            mem_valid,
    input  logic [DATA_SIZE-1:0]            mem_data,
    output logic                            fill_valid,
    output logic [PADDR_WIDTH-1:0]          fill_addr,
    output logic [DATA_SIZE*LINE_WORDS-1:0] fill_line,
    output logic [DATA_SIZE-1:0]            fill_word,
    output logic [ROB_WIDTH-1:0]            fill_tag
);

    localparam int OFF       = $clog2(LINE_WORDS * DATA_SIZE / 8);
    localparam int WOFF      = $clog2(DATA_SIZE / 8);
    localparam int IDXW      = $clog2(LINE_WORDS);
    localparam int LINE_BITS = DATA_SIZE * LINE_WORDS;

    typedef enum logic [2:0] {IDLE, REQ, FILL, DRAIN, RESP} state_t;

    state_t                 state, state_nxt;
    logic [IDXW-1:0]        cnt, cnt_nxt;
    logic [PADDR_WIDTH-1:0] line_addr_q;
    logic [IDXW-1:0]        word_idx_q;
    logic [ROB_WIDTH-1:0]   tag_q;
    logic [LINE_BITS-1:0]   line_buf;
    logic [LINE_BITS-1:0]   line_merged;
    logic [PADDR_WIDTH-1:0] miss_line_addr;
    logic                   beat_last;
    logic                   accept;
    logic                   line_wr;
    logic                   fill_done;

    assign miss_line_addr = {miss_paddr[PADDR_WIDTH-1:OFF], {OFF{1'b0}}};
    assign beat_last      = (cnt == IDXW'(LINE_WORDS - 1));

    // Line buffer with the current beat merged in, so the last beat can go
    // straight to the fill registers without an extra cycle.
    always_comb begin
        line_merged = line_buf;
        line_merged[cnt*DATA_SIZE +: DATA_SIZE] = mem_data;
    end

    // Next-state, beat counter and update strobes.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        line_wr   = 1'b0;
        fill_done = 1'b0;
        case (state)
            IDLE: begin
                if (miss_valid && !flush) begin
                    accept    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                state_nxt = flush ? DRAIN : FILL;
            end
            FILL: begin
                if (mem_valid) begin
                    cnt_nxt = beat_last ? '0 : cnt + IDXW'(1);
                end
                // A flush alongside the final beat means every beat is already absorbed.
                if (flush) begin
                    state_nxt = (mem_valid && beat_last) ? IDLE : DRAIN;
                end else if (mem_valid) begin
                    line_wr = 1'b1;
                    if (beat_last) begin
                        fill_done = 1'b1;
                        state_nxt = RESP;
                    end
                end
            end
            DRAIN: begin
                if (mem_valid) begin
                    cnt_nxt = beat_last ? '0 : cnt + IDXW'(1);
                    if (beat_last) begin
                        state_nxt = IDLE;
                    end
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Stall is gated by reset so a miss presented during reset does not freeze MEM.
    always_comb begin
        stall_MEM  = (state == IDLE) ? (reset && miss_valid && !flush) : (state != RESP);
        mem_req    = (state == REQ);
        fill_valid = (state == RESP);
    end

    assign mem_addr = line_addr_q;

    // State and beat counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Miss context captured at acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_addr_q <= '0;
            word_idx_q  <= '0;
            tag_q       <= '0;
        end else if (accept) begin
            line_addr_q <= miss_line_addr;
            word_idx_q  <= miss_paddr[OFF-1:WOFF];
            tag_q       <= miss_tag;
        end
    end

    // Beat collection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_buf <= '0;
        end else if (line_wr) begin
            line_buf <= line_merged;
        end
    end

    // Fill port registers; they hold until the next completed line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_addr <= '0;
            fill_line <= '0;
            fill_word <= '0;
            fill_tag  <= '0;
        end else if (fill_done) begin
            fill_addr <= line_addr_q;
            fill_line <= line_merged;
            fill_word <= line_merged[word_idx_q*DATA_SIZE +: DATA_SIZE];
            fill_tag  <= tag_q;
        end
    end

endmodule

// File: tb/tb_dcache_fill_unit.sv
// Testbench for dcache_fill_unit: directed misses, gaps, flushes and resets,
// checked every cycle against a transaction-level model plus literal values.
module tb_dcache_fill_unit;

    localparam int PW = 20;
    localparam int DW = 32;
    localparam int RW = 4;
    localparam int LW = 4;
    localparam int LINE_BYTES = LW * DW / 8;

    logic              clk;
    logic              reset;
    logic              miss_valid;
    logic [PW-1:0]     miss_paddr;
    logic [RW-1:0]     miss_tag;
    logic              flush;
    logic              stall_MEM;
    logic              mem_req;
    logic [PW-1:0]     mem_addr;
    logic              mem_valid;
    logic [DW-1:0]     mem_data;
    logic              fill_valid;
    logic [PW-1:0]     fill_addr;
    logic [DW*LW-1:0]  fill_line;
    logic [DW-1:0]     fill_word;
    logic [RW-1:0]     fill_tag;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_acc = 0;

    dcache_fill_unit #(.PADDR_WIDTH(PW), .DATA_SIZE(DW), .ROB_WIDTH(RW), .LINE_WORDS(LW)) dut (
        .clk(clk), .reset(reset), .miss_valid(miss_valid), .miss_paddr(miss_paddr),
        .miss_tag(miss_tag), .flush(flush), .stall_MEM(stall_MEM), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
        .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_line(fill_line),
        .fill_word(fill_word), .fill_tag(fill_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Transaction-level model: one outstanding miss, a list of absorbed beats,
    // and whether the miss was squashed before its line completed.
    bit              m_busy, m_req, m_resp, m_sq;
    int              m_beats, m_idx;
    logic [PW-1:0]   m_addr;
    logic [RW-1:0]   m_tag;
    logic [DW-1:0]   m_line [LW];
    logic [PW-1:0]   e_addr;
    logic [DW*LW-1:0] e_line;
    logic [DW-1:0]   e_word;
    logic [RW-1:0]   e_tag;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_req = 0; m_resp = 0; m_sq = 0; m_beats = 0; m_idx = 0;
            m_addr = '0; m_tag = '0;
            e_addr = '0; e_line = '0; e_word = '0; e_tag = '0;
        end else if (m_resp) begin
            m_resp = 0;
        end else if (!m_busy) begin
            if (miss_valid && !flush) begin
                m_busy  = 1;
                m_req   = 1;
                m_sq    = 0;
                m_beats = 0;
                m_addr  = PW'(int'(miss_paddr) - (int'(miss_paddr) % LINE_BYTES));
                m_idx   = (int'(miss_paddr) / (DW / 8)) % LW;
                m_tag   = miss_tag;
            end
        end else begin
            if (flush) m_sq = 1;
            if (!m_req && mem_valid) begin
                if (!m_sq) m_line[m_beats] = mem_data;
                m_beats++;
                if (m_beats == LW) begin
                    m_busy = 0;
                    if (!m_sq) begin
                        m_resp = 1;
                        e_addr = m_addr;
                        e_tag  = m_tag;
                        e_word = m_line[m_idx];
                        for (int i = 0; i < LW; i++) e_line[i*DW +: DW] = m_line[i];
                    end
                end
            end
            m_req = 0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("stall_MEM", stall_MEM,
            reset && (m_busy || (!m_resp && miss_valid && !flush)));
        chk("mem_req", mem_req, m_req);
        if (m_req) chk("mem_addr", mem_addr, m_addr);
        chk("fill_valid", fill_valid, m_resp);
        chk("fill_addr", fill_addr, e_addr);
        chk("fill_line", fill_line, e_line);
        chk("fill_word", fill_word, e_word);
        chk("fill_tag", fill_tag, e_tag);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a miss for one cycle (optionally left asserted) and checks the request.
    task automatic do_miss(input logic [PW-1:0] a, input logic [RW-1:0] t,
                           input logic [PW-1:0] exp_line, input bit hold);
        miss_valid = 1; miss_paddr = a; miss_tag = t;
        #1;
        chk("stall_on_miss", stall_MEM, 1'b1);
        @(posedge clk);
        #1;
        t_acc = cyc;
        if (!hold) miss_valid = 0;
        chk("req_pulse", mem_req, 1'b1);
        chk("req_addr", mem_addr, exp_line);
    endtask

    // From the REQ cycle: moves into FILL and delivers four beats with gaps.
    task automatic beats(input logic [DW-1:0] b0, b1, b2, b3, input int gap);
        logic [DW-1:0] b [LW];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        step();
        for (int k = 0; k < LW; k++) begin
            mem_valid = 1; mem_data = b[k];
            step();
            mem_valid = 0;
            if (k < LW - 1) repeat (gap) step();
        end
    endtask

    initial begin
        reset = 0; miss_valid = 0; miss_paddr = '0; miss_tag = '0;
        flush = 0; mem_valid = 0; mem_data = '0;
        repeat (2) step();
        chk("reset_fill_line", fill_line, 128'h0);
        chk("reset_stall", stall_MEM, 1'b0);
        #2 reset = 1;
        step();

        // Back-to-back beats.
        do_miss(20'h01234, 4'd5, 20'h01230, 0);
        beats(32'hA0, 32'hA1, 32'hA2, 32'hA3, 0);
        chk("t1_fill_valid", fill_valid, 1'b1);
        chk("t1_latency", cyc - t_acc, 5);
        chk("t1_line", fill_line, 128'h000000A3_000000A2_000000A1_000000A0);
        chk("t1_word", fill_word, 32'hA1);
        chk("t1_tag", fill_tag, 4'd5);
        chk("t1_addr", fill_addr, 20'h01230);
        chk("t1_stall_resp", stall_MEM, 1'b0);
        step();

        // Three idle cycles between beats.
        do_miss(20'h01234, 4'd5, 20'h01230, 0);
        beats(32'hA0, 32'hA1, 32'hA2, 32'hA3, 3);
        chk("t2_fill_valid", fill_valid, 1'b1);
        chk("t2_latency", cyc - t_acc, 14);
        chk("t2_line", fill_line, 128'h000000A3_000000A2_000000A1_000000A0);
        step();

        // Flush in the second FILL cycle; remaining beats are drained.
        do_miss(20'h05678, 4'd7, 20'h05670, 0);
        step();
        mem_valid = 1; mem_data = 32'hB0;
        step();
        mem_valid = 0; flush = 1;
        step();
        flush = 0;
        for (int k = 1; k < LW; k++) begin
            mem_valid = 1; mem_data = 32'hB0 + DW'(k);
            step();
        end
        mem_valid = 0;
        chk("t3_no_fill", fill_valid, 1'b0);
        chk("t3_idle_stall", stall_MEM, 1'b0);
        chk("t3_tag_held", fill_tag, 4'd5);
        step();
        do_miss(20'h00048, 4'd3, 20'h00040, 0);
        beats(32'hC0, 32'hC1, 32'hC2, 32'hC3, 1);
        chk("t3_refill_word", fill_word, 32'hC2);
        chk("t3_refill_tag", fill_tag, 4'd3);
        step();

        // Reset pulse after two beats.
        do_miss(20'h0ABCC, 4'd9, 20'h0ABC0, 0);
        step();
        for (int k = 0; k < 2; k++) begin
            mem_valid = 1; mem_data = 32'hD0 + DW'(k);
            step();
        end
        mem_valid = 0;
        #2 reset = 0;
        #1;
        chk("t4_stall", stall_MEM, 1'b0);
        chk("t4_req", mem_req, 1'b0);
        chk("t4_addr", mem_addr, 20'h0);
        chk("t4_fvalid", fill_valid, 1'b0);
        chk("t4_line", fill_line, 128'h0);
        chk("t4_word", fill_word, 32'h0);
        chk("t4_tag", fill_tag, 4'h0);
        chk("t4_faddr", fill_addr, 20'h0);
        @(posedge clk);
        #3 reset = 1;
        step();
        mem_valid = 1; mem_data = 32'hEE;
        repeat (2) step();
        mem_valid = 0;
        step();
        chk("t4_stray", fill_valid, 1'b0);
        do_miss(20'h0ABCC, 4'd9, 20'h0ABC0, 0);
        beats(32'hE0, 32'hE1, 32'hE2, 32'hE3, 0);
        chk("t4_line_after", fill_line, 128'h000000E3_000000E2_000000E1_000000E0);
        chk("t4_word_after", fill_word, 32'hE3);
        step();

        // Second miss held through the first RESP.
        do_miss(20'h00010, 4'd1, 20'h00010, 0);
        miss_valid = 1; miss_paddr = 20'h0002C; miss_tag = 4'd2;
        beats(32'h10, 32'h11, 32'h12, 32'h13, 0);
        chk("t5_first_word", fill_word, 32'h10);
        chk("t5_first_addr", fill_addr, 20'h00010);
        chk("t5_resp_noreq", mem_req, 1'b0);
        step();
        chk("t5_idle_stall", stall_MEM, 1'b1);
        step();
        miss_valid = 0;
        chk("t5_req2", mem_req, 1'b1);
        chk("t5_req2_addr", mem_addr, 20'h00020);
        beats(32'h20, 32'h21, 32'h22, 32'h23, 2);
        chk("t5_fill_addr", fill_addr, 20'h00020);
        chk("t5_fill_word", fill_word, 32'h23);
        chk("t5_fill_tag", fill_tag, 4'd2);
        step();

        // Miss with flush in IDLE is not accepted.
        miss_valid = 1; flush = 1; miss_paddr = 20'h00100; miss_tag = 4'd4;
        #1;
        chk("t6_stall", stall_MEM, 1'b0);
        step();
        miss_valid = 0; flush = 0;
        chk("t6_no_req", mem_req, 1'b0);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
